unsigned_approx_mul_pipe: RTL

UNSIGNED_APPROX_MUL_PIPE -- requirements
Module: unsigned_approx_mul_pipe

---
 rtl/approx_mul_pkg.sv | 19 +
 rtl/approx_mul_core.sv | 46 ++++
 rtl/unsigned_approx_mul_pipe.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/approx_mul_pkg.sv
// Shared definitions for the approximate unsigned multiplier pipeline:
// counter widths and the compensation-mask helper.
package approx_mul_pkg;

  localparam int unsigned TXN_CNT_W  = 32;
  localparam int unsigned ERR_ACC_W  = 48;
  localparam int unsigned MASK_MAX_W = 64;

  // Mask with every bit below column 'cut' cleared and all others set.
  function automatic logic [MASK_MAX_W-1:0] comp_mask(input int unsigned cut);
    logic [MASK_MAX_W-1:0] m;
    m = '1;
    for (int unsigned i = 0; i < MASK_MAX_W; i++) begin
      if (i < cut) m[i] = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/approx_mul_core.sv
// Combinational partial-product generator.
// hi_pp_o     : exact product of y with the upper multiplier rows x[WIDTH-1:L].
// comp_o      : OR-compressed low rows (x[L-1:0]) with columns below CUT cleared.
// low_exact_o : true sum of the low rows, so hi_pp_o + low_exact_o == x*y.
module approx_mul_core
  import approx_mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int L     = 2,
  parameter int CUT   = 7
) (
  input  logic [WIDTH-1:0]   x_i,
  input  logic [WIDTH-1:0]   y_i,
  output logic [2*WIDTH-1:0] hi_pp_o,
  output logic [2*WIDTH-1:0] comp_o,
  output logic [2*WIDTH-1:0] low_exact_o
);

  localparam int PW = 2 * WIDTH;
  localparam logic [PW-1:0] CUT_MASK = PW'(comp_mask(CUT));

  logic [PW-1:0] y_ext;
  logic [PW-1:0] x_hi_ext;
  logic [PW-1:0] or_acc;
  logic [PW-1:0] sum_acc;

  assign y_ext    = PW'(y_i);
  assign x_hi_ext = PW'(x_i >> L);
  assign hi_pp_o  = (y_ext * x_hi_ext) << L;

  // Low rows: OR them for the approximation, add them for the exact result.
  always_comb begin
    or_acc  = '0;
    sum_acc = '0;
    for (int r = 0; r < L; r++) begin
      if (x_i[r]) begin
        or_acc  = or_acc | (y_ext << r);
        sum_acc = sum_acc + (y_ext << r);
      end
    end
  end

  assign comp_o      = or_acc & CUT_MASK;
  assign low_exact_o = sum_acc;

endmodule

// File: rtl/unsigned_approx_mul_pipe.sv
// Two-stage valid/ready pipelined unsigned multiplier with optional
// low-row approximation per transaction.
// Optional feature macro: UNSIGNED_APPROX_MUL_ERRSTAT_EN adds err_acc, a
// saturating sum of |exact - z| over all output transfers.
//
// Handshake: a transfer happens on a side when valid and ready are both 1 at
// a rising clk edge. Producers hold data stable while valid=1 and ready=0;
// this block keeps z stable while out_valid=1 and out_ready=0. in_ready
// depends on out_ready and internal state only, never on in_valid.
module unsigned_approx_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int L     = 2,
  parameter int CUT   = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  input  logic                 approx_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   z,
`ifdef UNSIGNED_APPROX_MUL_ERRSTAT_EN
  output logic [ERR_ACC_W-1:0] err_acc,
`endif
  output logic [TXN_CNT_W-1:0] txn_count
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] core_hi;
  logic [PW-1:0] core_comp;
  logic [PW-1:0] core_low;

  // Stage 1 state
  logic          s1_valid_q, s1_valid_d;
  logic [PW-1:0] s1_hi_q, s1_hi_d;
  logic [PW-1:0] s1_comp_q, s1_comp_d;
  logic [PW-1:0] s1_low_q, s1_low_d;
  logic          s1_approx_q, s1_approx_d;

  // Stage 2 state
  logic          s2_valid_q, s2_valid_d;
  logic [PW-1:0] z_q, z_d;

  logic [TXN_CNT_W-1:0] txn_count_q, txn_count_d;

  logic s1_adv;
  logic s2_adv;
  logic out_fire;

  approx_mul_core #(
    .WIDTH (WIDTH),
    .L     (L),
    .CUT   (CUT)
  ) u_core (
    .x_i         (x),
    .y_i         (y),
    .hi_pp_o     (core_hi),
    .comp_o      (core_comp),
    .low_exact_o (core_low)
  );

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign out_fire = s2_valid_q && out_ready;

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign z         = z_q;
  assign txn_count = txn_count_q;

  // Next state of both pipeline stages.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_hi_d     = s1_hi_q;
    s1_comp_d   = s1_comp_q;
    s1_low_d    = s1_low_q;
    s1_approx_d = s1_approx_q;
    s2_valid_d  = s2_valid_q;
    z_d         = z_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_hi_d     = core_hi;
        s1_comp_d   = core_comp;
        s1_low_d    = core_low;
        s1_approx_d = approx_en;
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        z_d = s1_hi_q + (s1_approx_q ? s1_comp_q : s1_low_q);
      end
    end
  end

  // Saturating count of output transfers.
  always_comb begin
    txn_count_d = txn_count_q;
    if (out_fire && (txn_count_q != '1)) begin
      txn_count_d = txn_count_q + 1'b1;
    end
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_hi_q     <= '0;
      s1_comp_q   <= '0;
      s1_low_q    <= '0;
      s1_approx_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      z_q         <= '0;
      txn_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_hi_q     <= s1_hi_d;
      s1_comp_q   <= s1_comp_d;
      s1_low_q    <= s1_low_d;
      s1_approx_q <= s1_approx_d;
      s2_valid_q  <= s2_valid_d;
      z_q         <= z_d;
      txn_count_q <= txn_count_d;
    end
  end

`ifdef UNSIGNED_APPROX_MUL_ERRSTAT_EN
  localparam int SUM_W = PW + ERR_ACC_W + 1;

  logic [PW-1:0]        s2_exact_q, s2_exact_d;
  logic [PW-1:0]        err_diff;
  logic [SUM_W-1:0]     err_sum;
  logic [ERR_ACC_W-1:0] err_acc_q, err_acc_d;

  assign err_acc = err_acc_q;

  // Exact product travels with stage 2; absolute error accumulates on each output transfer.
  always_comb begin
    s2_exact_d = s2_exact_q;
    if (s2_adv && s1_valid_q) begin
      s2_exact_d = s1_hi_q + s1_low_q;
    end
    err_diff  = (s2_exact_q >= z_q) ? (s2_exact_q - z_q) : (z_q - s2_exact_q);
    err_sum   = SUM_W'(err_acc_q) + SUM_W'(err_diff);
    err_acc_d = err_acc_q;
    if (out_fire) begin
      err_acc_d = (|err_sum[SUM_W-1:ERR_ACC_W]) ? '1 : err_sum[ERR_ACC_W-1:0];
    end
  end

  // Error-statistic registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_exact_q <= '0;
      err_acc_q  <= '0;
    end else begin
      s2_exact_q <= s2_exact_d;
      err_acc_q  <= err_acc_d;
    end
  end
`endif

endmodule
